// File: rtl/gemm_0_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gemm_0_pkg
// Shared widths and accumulator FSM state type for the gemm_0 MAC datapath.
// Revision: 1.0
// ----------------------------------------------------------------------------
package gemm_0_pkg;

  localparam int GEMM_0_PROD_W = 23;
  localparam int GEMM_0_ACC_W  = 32;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_ACC  = 1'b1
  } gemm_0_acc_state_t;

endpackage
`default_nettype wire

// File: rtl/gemm_0_acc_sat_add.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gemm_0_acc_sat_add
// Signed accumulator adder; clamps to the signed range when GEMM_0_ACC_SAT_EN
// is defined, otherwise wraps modulo 2^WIDTH with ovf tied low.
// Revision: 1.0
// ----------------------------------------------------------------------------
module gemm_0_acc_sat_add
  import gemm_0_pkg::*;
#(
  parameter int WIDTH = GEMM_0_ACC_W
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] sum,
  output logic                    ovf
);

`ifdef GEMM_0_ACC_SAT_EN
  logic [WIDTH:0] full_w;
  logic           pos_ovf_w;
  logic           neg_ovf_w;

  assign full_w = {a[WIDTH-1], a} + {b[WIDTH-1], b};

  // The extra guard bit disagreeing with the top result bit marks overflow.
  assign pos_ovf_w = ~full_w[WIDTH] &  full_w[WIDTH-1];
  assign neg_ovf_w =  full_w[WIDTH] & ~full_w[WIDTH-1];

  always_comb begin
    sum = full_w[WIDTH-1:0];
    if (pos_ovf_w) begin
      sum = {1'b0, {(WIDTH-1){1'b1}}};
    end else if (neg_ovf_w) begin
      sum = {1'b1, {(WIDTH-1){1'b0}}};
    end
  end

  assign ovf = pos_ovf_w | neg_ovf_w;
`else
  assign sum = a + b;
  assign ovf = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/gemm_0_mac_acc.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gemm_0_mac_acc
// Accumulates K_LEN signed products into one dot-product result with a
// valid/ready output stage. Optional clamp: GEMM_0_ACC_SAT_EN.
// Revision: 1.0
// ----------------------------------------------------------------------------
module gemm_0_mac_acc
  import gemm_0_pkg::*;
#(
  parameter int DIN_WIDTH  = GEMM_0_PROD_W,
  parameter int DOUT_WIDTH = GEMM_0_ACC_W,
  parameter int K_LEN      = 16
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  input  logic signed [DIN_WIDTH-1:0]  in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic signed [DOUT_WIDTH-1:0] out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_sat
);

  localparam int              CNT_W    = (K_LEN > 1) ? $clog2(K_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K_LEN - 1);

  gemm_0_acc_state_t state_q, state_d;

  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic signed [DOUT_WIDTH-1:0] acc_q, acc_d;
  logic signed [DOUT_WIDTH-1:0] out_data_q, out_data_d;
  logic                         sat_q, sat_d;
  logic                         out_valid_q, out_valid_d;
  logic                         out_sat_q, out_sat_d;

  logic signed [DOUT_WIDTH-1:0] din_ext_w;
  logic signed [DOUT_WIDTH-1:0] acc_in_w;
  logic signed [DOUT_WIDTH-1:0] sum_w;
  logic                         ovf_w;
  logic                         last_w;
  logic                         accept_w;

  assign din_ext_w = DOUT_WIDTH'(in_data);
  // A group always starts from zero, so the idle state feeds a clean operand.
  assign acc_in_w  = (state_q == S_IDLE) ? '0 : acc_q;

  gemm_0_acc_sat_add #(
    .WIDTH (DOUT_WIDTH)
  ) u_add (
    .a   (acc_in_w),
    .b   (din_ext_w),
    .sum (sum_w),
    .ovf (ovf_w)
  );

  assign last_w   = (cnt_q == CNT_LAST);
  assign in_ready = !last_w || !out_valid_q || out_ready;
  assign accept_w = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept_w && !last_w) state_d = S_ACC;
      S_ACC:   if (accept_w && last_w)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    sat_d       = sat_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_sat_d   = out_sat_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // A final beat overrides the drain above so back-to-back results keep valid high.
    if (accept_w) begin
      if (last_w) begin
        out_data_d  = sum_w;
        out_valid_d = 1'b1;
        out_sat_d   = sat_q | ovf_w;
        acc_d       = '0;
        cnt_d       = '0;
        sat_d       = 1'b0;
      end else begin
        acc_d = sum_w;
        cnt_d = cnt_q + CNT_W'(1);
        sat_d = sat_q | ovf_w;
      end
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      sat_q       <= sat_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_sat   = out_sat_q;

endmodule
`default_nettype wire

// File: tb/tb_gemm_0_mac_acc.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_gemm_0_mac_acc
// Four differently-parameterised instances driven by a directed vector table,
// a reset-mid-group sequence and a randomized run against a group-sum model.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_gemm_0_mac_acc;

  localparam int NI = 4;

  function automatic int k_of(input int i);
    case (i)
      0: return 4;
      1: return 2;
      2: return 1;
      default: return 4;
    endcase
  endfunction

  function automatic int dw_of(input int i);
    return (i == 3) ? 24 : 32;
  endfunction

`ifdef GEMM_0_ACC_SAT_EN
  localparam int EXP33 = 8388607;
  localparam bit SAT33 = 1'b1;
`else
  localparam int EXP33 = -4;
  localparam bit SAT33 = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0][22:0] in_data;
  logic [NI-1:0]       in_valid;
  logic [NI-1:0]       out_ready;
  logic [NI-1:0]       in_ready;
  logic [NI-1:0]       out_valid;
  logic [NI-1:0]       out_sat;
  logic [NI-1:0][31:0] od;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [dw_of(g)-1:0] od_w;
    gemm_0_mac_acc #(
      .DIN_WIDTH  (23),
      .DOUT_WIDTH (dw_of(g)),
      .K_LEN      (k_of(g))
    ) u_dut (
      .ap_clk    (clk),
      .ap_rst    (rst),
      .in_data   (in_data[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .out_data  (od_w),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_sat   (out_sat[g])
    );
    assign od[g] = 32'($signed(od_w));
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    int inst;
    bit v;
    int d;
    bit ordy;
    bit erdy;
    bit eov;
    int eod;
    bit esat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int inst, input bit v, input int d, input bit ordy,
                              input bit erdy, input bit eov, input int eod, input bit esat);
    vec_t x;
    x.inst = inst; x.v = v; x.d = d; x.ordy = ordy;
    x.erdy = erdy; x.eov = eov; x.eod = eod; x.esat = esat;
    return x;
  endfunction

  // One cycle: drive at negedge, check ready before the edge, outputs after it.
  task automatic apply(input vec_t x);
    @(negedge clk);
    in_valid  = '0;
    out_ready = '1;
    in_valid[x.inst]  = x.v;
    in_data[x.inst]   = 23'(x.d);
    out_ready[x.inst] = x.ordy;
    #1;
    chk($sformatf("in_ready[%0d]", x.inst), in_ready[x.inst], x.erdy);
    @(posedge clk);
    #1;
    chk($sformatf("out_valid[%0d]", x.inst), out_valid[x.inst], x.eov);
    if (x.eov) begin
      chk($sformatf("out_data[%0d]", x.inst), $signed(od[x.inst]), x.eod);
      chk($sformatf("out_sat[%0d]", x.inst), out_sat[x.inst], x.esat);
    end
  endtask

  // Behavioural model: collect the group's terms, fold them when the group completes.
  longint mterms [NI][16];
  int     mn [NI];
  bit     mv [NI];
  longint md [NI];
  bit     ms [NI];

  function automatic longint fold(input int i, output bit sat);
    longint one = 1;
    longint s   = 0;
    int     w   = dw_of(i);
    longint hi  = (one << (w - 1)) - 1;
    longint lo  = -(one << (w - 1));
    sat = 1'b0;
    for (int k = 0; k < k_of(i); k++) begin
      s = s + mterms[i][k];
`ifdef GEMM_0_ACC_SAT_EN
      if (s > hi) begin s = hi; sat = 1'b1; end
      else if (s < lo) begin s = lo; sat = 1'b1; end
`else
      s = (s <<< (64 - w)) >>> (64 - w);
`endif
    end
    return s;
  endfunction

  initial begin
    in_valid  = '0;
    out_ready = '1;
    in_data   = '0;
    for (int i = 0; i < NI; i++) begin
      mn[i] = 0; mv[i] = 1'b0; md[i] = 0; ms[i] = 1'b0;
    end

    #1 rst = 1'b1;
    #2;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_out_valid[%0d]", i), out_valid[i], 0);
      chk($sformatf("rst_out_data[%0d]", i), $signed(od[i]), 0);
      chk($sformatf("rst_out_sat[%0d]", i), out_sat[i], 0);
      chk($sformatf("rst_in_ready[%0d]", i), in_ready[i], 1);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // K=4 basic, back-to-back
    vecs.push_back(mk(0, 1, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 2, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 3, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4, 1, 1, 1, 10, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0));
    // bubbles in in_valid are ignored
    vecs.push_back(mk(0, 1, 7, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1000, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 1, 1, 10, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0));
    // most-negative products
    for (int k = 0; k < 3; k++) vecs.push_back(mk(0, 1, -4194304, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, -4194304, 1, 1, 1, -16777216, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0));
    // 24-bit accumulator overflow
    for (int k = 0; k < 3; k++) vecs.push_back(mk(3, 1, 4194303, 1, 1, 0, 0, 0));
    vecs.push_back(mk(3, 1, 4194303, 1, 1, 1, EXP33, SAT33));
    vecs.push_back(mk(3, 0, 0, 1, 1, 0, 0, 0));
    // K=2 backpressure
    vecs.push_back(mk(1, 1, 5, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 6, 0, 1, 1, 11, 0));
    vecs.push_back(mk(1, 1, 7, 0, 1, 1, 11, 0));
    vecs.push_back(mk(1, 1, 8, 0, 0, 1, 11, 0));
    vecs.push_back(mk(1, 1, 8, 0, 0, 1, 11, 0));
    vecs.push_back(mk(1, 1, 8, 1, 1, 1, 15, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0));
    // K=1 every beat is final
    vecs.push_back(mk(2, 1, 3, 1, 1, 1, 3, 0));
    vecs.push_back(mk(2, 1, -3, 1, 1, 1, -3, 0));
    vecs.push_back(mk(2, 0, 0, 1, 1, 0, 0, 0));

    foreach (vecs[n]) apply(vecs[n]);

    // Reset mid-group while a result is held
    for (int k = 0; k < 3; k++) apply(mk(0, 1, 2, 0, 1, 0, 0, 0));
    apply(mk(0, 1, 2, 0, 1, 1, 8, 0));
    apply(mk(0, 1, 9, 0, 1, 1, 8, 0));
    apply(mk(0, 1, 9, 0, 1, 1, 8, 0));
    @(negedge clk);
    in_valid = '0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", out_valid[0], 0);
    chk("async_rst_out_data", $signed(od[0]), 0);
    chk("async_rst_in_ready", in_ready[0], 1);
    #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) apply(mk(0, 1, 1, 1, 1, 0, 0, 0));
    apply(mk(0, 1, 1, 1, 1, 1, 4, 0));
    apply(mk(0, 0, 0, 1, 1, 0, 0, 0));

    // Randomized run on the K=4 instances (32-bit and 24-bit accumulators)
    in_valid  = '0;
    out_ready = '1;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      for (int j = 0; j < 2; j++) begin
        int i;
        i = (j == 0) ? 0 : 3;
        chk($sformatf("rnd_out_valid[%0d]", i), out_valid[i], mv[i]);
        if (mv[i]) begin
          chk($sformatf("rnd_out_data[%0d]", i), $signed(od[i]), md[i]);
          chk($sformatf("rnd_out_sat[%0d]", i), out_sat[i], ms[i]);
        end
        in_valid[i]  = ($urandom_range(3) != 0);
        in_data[i]   = 23'($urandom);
        out_ready[i] = 1'($urandom_range(1));
      end
      #1;
      for (int j = 0; j < 2; j++) begin
        int i;
        bit er;
        bit s;
        i  = (j == 0) ? 0 : 3;
        er = (mn[i] != k_of(i) - 1) || !mv[i] || out_ready[i];
        chk($sformatf("rnd_in_ready[%0d]", i), in_ready[i], er);
        if (in_valid[i] && er) begin
          mterms[i][mn[i]] = longint'($signed(in_data[i]));
          mn[i]++;
          if (mn[i] == k_of(i)) begin
            md[i] = fold(i, s);
            ms[i] = s;
            mv[i] = 1'b1;
            mn[i] = 0;
          end else if (mv[i] && out_ready[i]) begin
            mv[i] = 1'b0;
          end
        end else if (mv[i] && out_ready[i]) begin
          mv[i] = 1'b0;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
